// File: rtl/twiddle_gen.sv
// Streaming twiddle-factor generator. Each accepted request produces a burst
// of beats. Every beat carries LANES cos/sin pairs for the indices
// start + n*step (mod N). Values come from one quarter-wave sine ROM that is
// built at elaboration with round-half-away-from-zero entries.
module twiddle_gen #(
    parameter int LOG2N = 6,
    parameter int LANES = 8,
    parameter int WIDTH = 16,
    parameter int FRAC  = 8,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [LOG2N-1:0]         req_start,
    input  logic [LOG2N-1:0]         req_step,
    input  logic [CNT_W-1:0]         req_beats_m1,
    input  logic                     req_conj,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_last,
    output logic [LANES*WIDTH-1:0]   cos_out,
    output logic [LANES*WIDTH-1:0]   sin_out
);

    localparam int N         = 1 << LOG2N;
    localparam int QTR       = N / 4;
    // The ROM index must reach QTR itself, so it needs one bit more than r.
    localparam int RW        = LOG2N - 1;
    localparam int ANG_SHIFT = 30;
    // pi scaled by 2^30; the angle arithmetic below uses that fixed point.
    localparam longint PI_SCALED = 64'sd3373259426;

    // The table is evaluated once at elaboration. A Taylor series in 64-bit
    // fixed point gives an error far below half an output LSB. Because the
    // angle stays in [0, pi/2], the sum is never negative, so adding half an
    // LSB before the shift rounds half away from zero.
    function automatic logic [(QTR+1)*WIDTH-1:0] build_rom();
        logic [(QTR+1)*WIDTH-1:0] rom;
        longint x, term, sum, val;
        rom = '0;
        for (int j = 0; j <= QTR; j++) begin
            x    = (64'sd2 * PI_SCALED * longint'(j)) / longint'(N);
            term = x;
            sum  = x;
            for (int n = 1; n <= 12; n++) begin
                term = -((term * x) >>> ANG_SHIFT);
                term = (term * x) >>> ANG_SHIFT;
                term = term / longint'((2 * n) * (2 * n + 1));
                sum  = sum + term;
            end
            val = ((sum <<< FRAC) + (64'sd1 <<< (ANG_SHIFT - 1))) >>> ANG_SHIFT;
            rom[j*WIDTH +: WIDTH] = WIDTH'(val);
        end
        return rom;
    endfunction

    localparam logic [(QTR+1)*WIDTH-1:0] ROM = build_rom();

    // Quarter-wave folding. Odd quadrants read the table mirrored, and the
    // lower half-circle negates. T[0] is zero, so negating it gives 0, not -0.
    function automatic logic signed [WIDTH-1:0] sin_lut(input logic [LOG2N-1:0] k);
        logic [1:0]              q;
        logic [RW-1:0]           r;
        logic [RW-1:0]           idx;
        logic signed [WIDTH-1:0] mag;
        q   = k[LOG2N-1 -: 2];
        r   = {1'b0, k[LOG2N-3:0]};
        idx = q[0] ? (RW'(QTR) - r) : r;
        mag = ROM[int'(idx)*WIDTH +: WIDTH];
        return q[1] ? -mag : mag;
    endfunction

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t                   state_q, state_d;
    logic [LOG2N-1:0]         base_q, base_d;
    logic [LOG2N-1:0]         step_q, step_d;
    logic [CNT_W-1:0]         beat_q, beat_d;
    logic [CNT_W-1:0]         beats_m1_q, beats_m1_d;
    logic                     conj_q, conj_d;
    logic                     out_valid_q, out_valid_d;
    logic                     out_last_q, out_last_d;
    logic [LANES*WIDTH-1:0]   cos_q, cos_d;
    logic [LANES*WIDTH-1:0]   sin_q, sin_d;
    logic                     load_beat;
    logic [LOG2N-1:0]         lane_idx;
    logic signed [WIDTH-1:0]  sin_v;

    assign req_ready = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign cos_out   = cos_q;
    assign sin_out   = sin_q;

    // Control path: accept a request, present beats, and advance base and beat on each handshake.
    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        step_d      = step_q;
        beat_d      = beat_q;
        beats_m1_d  = beats_m1_q;
        conj_d      = conj_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        load_beat   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    base_d     = req_start;
                    step_d     = req_step;
                    beats_m1_d = req_beats_m1;
                    conj_d     = req_conj;
                    beat_d     = '0;
                    state_d    = RUN;
                end
            end
            RUN: begin
                if (!out_valid_q) begin
                    load_beat   = 1'b1;
                    out_valid_d = 1'b1;
                end else if (out_ready) begin
                    if (out_last_q) begin
                        state_d     = IDLE;
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                    end else begin
                        base_d    = base_q + LOG2N'(LANES) * step_q;
                        beat_d    = beat_q + CNT_W'(1);
                        load_beat = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (load_beat) begin
            out_last_d = (beat_d == beats_m1_q);
        end
    end

    // Lane datapath: compute every lane of the next beat from the base of that beat.
    always_comb begin
        cos_d    = cos_q;
        sin_d    = sin_q;
        lane_idx = '0;
        sin_v    = '0;
        if (load_beat) begin
            for (int i = 0; i < LANES; i++) begin
                lane_idx = base_d + LOG2N'(i) * step_q;
                cos_d[i*WIDTH +: WIDTH] = sin_lut(lane_idx + LOG2N'(QTR));
                sin_v = sin_lut(lane_idx);
                sin_d[i*WIDTH +: WIDTH] = conj_q ? -sin_v : sin_v;
            end
        end
    end

    // State, burst bookkeeping and output registers; reset drops any burst in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            base_q      <= '0;
            step_q      <= '0;
            beat_q      <= '0;
            beats_m1_q  <= '0;
            conj_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            cos_q       <= '0;
            sin_q       <= '0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            step_q      <= step_d;
            beat_q      <= beat_d;
            beats_m1_q  <= beats_m1_d;
            conj_q      <= conj_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            cos_q       <= cos_d;
            sin_q       <= sin_d;
        end
    end

endmodule

// File: tb/tb_twiddle_gen.sv
// Bench for twiddle_gen. It uses a default-size instance and a wider
// LOG2N=8, LANES=4 instance. A real-valued sin/cos model predicts each beat.
module tb_twiddle_gen;

    localparam int LOG2N = 6, LANES = 8, WIDTH = 16, FRAC = 8, CNT_W = 8;
    localparam int N  = 1 << LOG2N;
    localparam int L2B = 8, LB = 4, WB = 18, FB = 15;
    localparam int NB = 1 << L2B;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic                   req_valid = 1'b0, req_ready, req_conj = 1'b0;
    logic [LOG2N-1:0]       req_start = '0, req_step = '0;
    logic [CNT_W-1:0]       req_beats_m1 = '0;
    logic                   out_valid, out_ready = 1'b1, out_last;
    logic [LANES*WIDTH-1:0] cos_out, sin_out;

    logic                   req_valid2 = 1'b0, req_ready2, req_conj2 = 1'b0;
    logic [L2B-1:0]         req_start2 = '0, req_step2 = '0;
    logic [CNT_W-1:0]       req_beats_m12 = '0;
    logic                   out_valid2, out_last2;
    logic                   out_ready2 = 1'b1;
    logic [LB*WB-1:0]       cos_out2, sin_out2;

    twiddle_gen #(.LOG2N(LOG2N), .LANES(LANES), .WIDTH(WIDTH), .FRAC(FRAC), .CNT_W(CNT_W)) u_dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_start(req_start), .req_step(req_step), .req_beats_m1(req_beats_m1),
        .req_conj(req_conj), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .cos_out(cos_out), .sin_out(sin_out)
    );

    twiddle_gen #(.LOG2N(L2B), .LANES(LB), .WIDTH(WB), .FRAC(FB), .CNT_W(CNT_W)) u_dut_wide (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid2), .req_ready(req_ready2),
        .req_start(req_start2), .req_step(req_step2), .req_beats_m1(req_beats_m12),
        .req_conj(req_conj2), .out_valid(out_valid2), .out_ready(out_ready2),
        .out_last(out_last2), .cos_out(cos_out2), .sin_out(sin_out2)
    );

    int checks = 0;
    int errors = 0;
    int hs_count = 0;

    typedef struct {
        logic [LANES*WIDTH-1:0] c;
        logic [LANES*WIDTH-1:0] s;
        logic                   last;
    } exp_beat_t;
    exp_beat_t model_q[$];

    int t1_sin[8] = '{0, 25, 50, 74, 98, 121, 142, 162};
    int t1_cos[8] = '{256, 255, 251, 245, 237, 226, 213, 198};
    int t2_sin[8] = '{0, 181, 256, 181, 0, -181, -256, -181};
    int t2_cos[8] = '{256, 181, 0, -181, -256, -181, 0, 181};
    int t6_sin[4] = '{0, 32768, 0, -32768};
    int t6_cos[4] = '{32768, 0, -32768, 0};
    int t4_ready[6] = '{1, 0, 0, 1, 0, 1};

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic checkVec(input string name, input logic [127:0] actual, input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    function automatic int rnd(input real x);
        if (x >= 0.0) return $rtoi(x + 0.5);
        return -$rtoi(-x + 0.5);
    endfunction

    function automatic int model_sin(input int k, input int n, input int frac, input bit conj);
        real a;
        int v;
        a = 2.0 * 3.14159265358979323846 * real'(k) / real'(n);
        v = rnd($sin(a) * real'(1 << frac));
        return conj ? -v : v;
    endfunction

    function automatic int model_cos(input int k, input int n, input int frac);
        real a;
        a = 2.0 * 3.14159265358979323846 * real'(k) / real'(n);
        return rnd($cos(a) * real'(1 << frac));
    endfunction

    function automatic int lane1(input logic [LANES*WIDTH-1:0] v, input int i);
        logic signed [WIDTH-1:0] s;
        s = v[i*WIDTH +: WIDTH];
        return int'(s);
    endfunction

    function automatic int lane2(input logic [LB*WB-1:0] v, input int i);
        logic signed [WB-1:0] s;
        s = v[i*WB +: WB];
        return int'(s);
    endfunction

    task automatic pushBurst(input int start, input int step, input int bm1, input bit conj);
        exp_beat_t e;
        for (int b = 0; b <= bm1; b++) begin
            for (int i = 0; i < LANES; i++) begin
                int k;
                k = (start + (b * LANES + i) * step) % N;
                e.c[i*WIDTH +: WIDTH] = WIDTH'(model_cos(k, N, FRAC));
                e.s[i*WIDTH +: WIDTH] = WIDTH'(model_sin(k, N, FRAC, conj));
            end
            e.last = (b == bm1);
            model_q.push_back(e);
        end
    endtask

    // Model checker: queue expected beats at request handshake, compare every presented beat
    always @(negedge clk) begin
        exp_beat_t e;
        if (rst_n) begin
            if (req_valid && req_ready)
                pushBurst(int'(req_start), int'(req_step), int'(req_beats_m1), req_conj);
            if (out_valid) begin
                checkOutput("model_beat_expected", int'(model_q.size() != 0), 1);
                if (model_q.size() != 0) begin
                    e = model_q[0];
                    checkVec("model_cos", cos_out, e.c);
                    checkVec("model_sin", sin_out, e.s);
                    checkOutput("model_last", int'(out_last), int'(e.last));
                    if (out_ready) begin
                        void'(model_q.pop_front());
                        hs_count++;
                    end
                end
            end
        end
    end

    task automatic applyStimulus(input int start, input int step, input int bm1, input bit conj);
        @(posedge clk);
        #1;
        req_start    = LOG2N'(start);
        req_step     = LOG2N'(step);
        req_beats_m1 = CNT_W'(bm1);
        req_conj     = conj;
        req_valid    = 1'b1;
        @(posedge clk);
        #1;
        req_valid    = 1'b0;
        req_start    = ~req_start;
        req_step     = ~req_step;
        req_beats_m1 = ~req_beats_m1;
        req_conj     = ~req_conj;
    endtask

    task automatic applyStimulusWide(input int start, input int step, input int bm1, input bit conj);
        @(posedge clk);
        #1;
        req_start2    = L2B'(start);
        req_step2     = L2B'(step);
        req_beats_m12 = CNT_W'(bm1);
        req_conj2     = conj;
        req_valid2    = 1'b1;
        @(posedge clk);
        #1;
        req_valid2    = 1'b0;
        req_start2    = ~req_start2;
        req_step2     = ~req_step2;
    endtask

    initial begin
        int hs_base;
        int st, sp, bm;
        bit cj;

        // Reset state
        #12;
        checkOutput("rst_req_ready", int'(req_ready), 1);
        checkOutput("rst_out_valid", int'(out_valid), 0);
        checkOutput("rst_out_last", int'(out_last), 0);
        checkVec("rst_cos_zero", cos_out, 128'd0);
        #10;
        rst_n = 1'b1;

        // Test 1: basic burst of eight beats
        out_ready = 1'b1;
        applyStimulus(0, 1, 7, 1'b0);
        @(negedge clk);
        checkOutput("t1_gap_valid", int'(out_valid), 0);
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            checkOutput($sformatf("t1_sin%0d", i), lane1(sin_out, i), t1_sin[i]);
            checkOutput($sformatf("t1_cos%0d", i), lane1(cos_out, i), t1_cos[i]);
        end
        for (int b = 0; b < 8; b++) begin
            checkOutput($sformatf("t1_valid_b%0d", b), int'(out_valid), 1);
            checkOutput($sformatf("t1_last_b%0d", b), int'(out_last), (b == 7) ? 1 : 0);
            @(negedge clk);
        end
        checkOutput("t1_ready_after", int'(req_ready), 1);
        checkOutput("t1_valid_after", int'(out_valid), 0);

        // Test 2: quadrant exactness
        applyStimulus(0, 8, 0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            checkOutput($sformatf("t2_sin%0d", i), lane1(sin_out, i), t2_sin[i]);
            checkOutput($sformatf("t2_cos%0d", i), lane1(cos_out, i), t2_cos[i]);
        end
        checkOutput("t2_last", int'(out_last), 1);

        // Test 3: conjugate with index wrap
        applyStimulus(60, 2, 0, 1'b1);
        @(negedge clk);
        @(negedge clk);
        checkOutput("t3_sin2", lane1(sin_out, 2), 0);
        checkOutput("t3_sin4", lane1(sin_out, 4), -98);
        checkOutput("t3_sin6", lane1(sin_out, 6), -181);
        checkOutput("t3_cos0", lane1(cos_out, 0), 237);

        // Test 4: back-pressure over a three-beat burst
        @(negedge clk);
        hs_base = hs_count;
        applyStimulus(5, 3, 2, 1'b0);
        @(negedge clk);
        for (int p = 0; p < 6; p++) begin
            @(posedge clk);
            #1;
            out_ready = t4_ready[p][0];
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("t4_handshakes", hs_count - hs_base, 3);
        checkOutput("t4_queue_empty", model_q.size(), 0);
        checkOutput("t4_valid_after", int'(out_valid), 0);

        // Test 5: asynchronous reset during beat 2
        applyStimulus(0, 1, 7, 1'b0);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("t5_valid", int'(out_valid), 0);
        checkOutput("t5_last", int'(out_last), 0);
        checkOutput("t5_ready", int'(req_ready), 1);
        checkVec("t5_cos", cos_out, 128'd0);
        checkVec("t5_sin", sin_out, 128'd0);
        model_q.delete();
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("t5_ready_rel", int'(req_ready), 1);
        checkOutput("t5_valid_rel", int'(out_valid), 0);
        applyStimulus(3, 1, 0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        checkOutput("t5_new_valid", int'(out_valid), 1);
        checkOutput("t5_new_last", int'(out_last), 1);
        checkOutput("t5_new_sin0", lane1(sin_out, 0), 74);
        @(negedge clk);
        checkOutput("t5_queue_empty", model_q.size(), 0);

        // Test 6: wide instance, exact quadrant points then random requests
        applyStimulusWide(0, 64, 0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < LB; i++) begin
            checkOutput($sformatf("t6_sin%0d", i), lane2(sin_out2, i), t6_sin[i]);
            checkOutput($sformatf("t6_cos%0d", i), lane2(cos_out2, i), t6_cos[i]);
        end
        for (int t = 0; t < 6; t++) begin
            st = int'($urandom_range(0, NB - 1));
            sp = int'($urandom_range(0, NB - 1));
            bm = int'($urandom_range(0, 2));
            cj = 1'($urandom_range(0, 1));
            applyStimulusWide(st, sp, bm, cj);
            @(negedge clk);
            for (int b = 0; b <= bm; b++) begin
                @(negedge clk);
                checkOutput("t6_valid", int'(out_valid2), 1);
                checkOutput("t6_last", int'(out_last2), (b == bm) ? 1 : 0);
                for (int i = 0; i < LB; i++) begin
                    int k;
                    k = (st + (b * LB + i) * sp) % NB;
                    checkOutput($sformatf("t6_sin_k%0d", k), lane2(sin_out2, i), model_sin(k, NB, FB, cj));
                    checkOutput($sformatf("t6_cos_k%0d", k), lane2(cos_out2, i), model_cos(k, NB, FB));
                end
            end
            @(negedge clk);
            checkOutput("t6_valid_after", int'(out_valid2), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/twiddle_gen.md
Name: twiddle_gen

Overview:
- Streaming twiddle-factor generator for the FFT datapath, successor to the combinational sin/cos lookup.
- Parametrised in transform size, lane count, width and fraction bits.
- Uses a single quarter-wave ROM with round-to-nearest entries and an optional conjugate mode.
- On a request it emits a burst of beats; each beat carries LANES cos/sin pairs for indices start + n*step mod N, under a valid/ready handshake.

Parameters:
- LOG2N, 6: log2 of transform size N; must be ≥ 3.
- LANES, 8: twiddle pairs per output beat.
- WIDTH, 16: signed output width.
- FRAC, 8: fraction bits; 1.0 = 2^FRAC. Requires WIDTH ≥ FRAC+2.
- CNT_W, 8: width of the burst-length field.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when high with req_valid.
- req_start  in  LOG2N  first index.
- req_step  in  LOG2N  index stride between consecutive twiddles.
- req_beats_m1  in  CNT_W  number of beats minus one.
- req_conj  in  1  1 = negate sin outputs (e^{-j} convention).
- out_valid  out  1  beat present.
- out_ready  in  1  consumer accepts beat.
- out_last  out  1  final beat of burst.
- cos_out  out  LANES x WIDTH signed  cos(2*pi*k/N)*2^FRAC per lane.
- sin_out  out  LANES x WIDTH signed  ±sin(2*pi*k/N)*2^FRAC per lane.

Behaviour:
- ROM: T[j] = round-half-away(sin(2*pi*j/N)*2^FRAC), j = 0..N/4, constant at elaboration. No runtime writes.
- Index for lane i of beat b: k = (req_start + (b*LANES + i)*req_step) mod N, with natural LOG2N-bit wrap.
- Implementation keeps a base register, initialised to req_start and advanced by LANES*req_step (mod N) per accepted beat.
- Quarter mapping for sin, with q = k[LOG2N-1:LOG2N-2] and r = k mod N/4:
  - q0: T[r]
  - q1: T[N/4-r]
  - q2: -T[r]
  - q3: -T[N/4-r]
- cos(k) = sin((k + N/4) mod N). Exact ±2^FRAC at k = 0, N/4, N/2, 3N/4; no zero-of-negative artefacts.
- Conjugate: when the latched conj bit is 1, sin_out lanes are the two's-complement negation. cos_out is unaffected. Applies to the whole burst.
- FSM states IDLE and RUN.
  - IDLE: req_ready = 1, out_valid = 0. On req_valid, latch start, step, beats_m1 and conj; go to RUN.
  - RUN: req_ready = 0. Beat b is presented registered with out_valid = 1. out_last = 1 iff b == beats_m1.
  - On out_valid && out_ready: advance b and base. If the beat was last, go to IDLE and deassert out_valid next cycle.
- Latency: request accepted at edge T → beat 0 valid after edge T+1.
- One beat per cycle while out_ready stays high. Burst of B beats occupies B+1 cycles including the return to IDLE.
- Back-pressure: while out_valid && !out_ready, all outputs (cos_out, sin_out, out_last) hold stable. Index state does not advance.
- Boundaries:
  - req_beats_m1 = 0 gives a single beat with out_last = 1.
  - req_step = 0 gives all lanes equal to index start.
  - Index wrap past N-1 is silent.
  - Request inputs are ignored outside the IDLE handshake cycle.
- Reset (asynchronous, any time, including mid-burst) forces IDLE, req_ready = 1, out_valid = 0, out_last = 0, cos_out/sin_out lanes = 0, beat counter and base = 0. Any burst in progress is dropped.

Test Plan:
1. Defaults; start=0, step=1, beats_m1=7, conj=0, out_ready=1 → beat0 sin = 0,25,50,74,98,121,142,162 and cos = 256,255,251,245,237,226,213,198. Eight beats on consecutive cycles; out_last only on beat 7; req_ready high again the cycle after beat 7.
2. Quadrant exactness: start=0, step=8, beats_m1=0 → sin = 0,181,256,181,0,-181,-256,-181; cos = 256,181,0,-181,-256,-181,0,181.
3. Conjugate and wrap: start=60, step=2, beats_m1=0, conj=1 → indices 60,62,0,2,4,6,8,10. sin_out lane 2 = 0, lane 4 = -98, lane 6 = -181. cos_out lane 0 = 237.
4. Back-pressure: burst of 3 beats with out_ready toggling 1,0,0,1,0,1 → each beat held unchanged while stalled. Exactly 3 handshakes, no duplicates or skips.
5. Reset mid-burst: assert rst_n = 0 asynchronously during beat 2 of 8 → outputs zero immediately. After release req_ready = 1, out_valid = 0; a new request starts cleanly at beat 0.
6. Parameter sweep LOG2N=8, LANES=4, WIDTH=18, FRAC=15: random start/step/conj → every lane matches the reference model round(sin/cos*32768), with ±32768 exact at the quadrant points.
